// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised Fibonacci LFSR period generator.
// FSM encoding, supported widths and the tap table live here.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STUCK
    } lfsr_fsm_e;

    localparam int unsigned LFSR_N_WIDTHS = 7;
    localparam int unsigned LFSR_WIDTHS [LFSR_N_WIDTHS] =
        '{4, 8, 16, 24, 32, 48, 64};

    // Bit p-1 set for each 1-based tap position p; zero for unsupported widths.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] m;
        m = '0;
        case (width)
            4:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
            8:  begin m[7]  = 1'b1; m[5]  = 1'b1; m[4]  = 1'b1; m[3]  = 1'b1; end
            16: begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3]  = 1'b1; end
            24: begin m[23] = 1'b1; m[22] = 1'b1; m[21] = 1'b1; m[16] = 1'b1; end
            32: begin m[31] = 1'b1; m[21] = 1'b1; m[1]  = 1'b1; m[0]  = 1'b1; end
            48: begin m[47] = 1'b1; m[46] = 1'b1; m[20] = 1'b1; m[19] = 1'b1; end
            64: begin m[63] = 1'b1; m[62] = 1'b1; m[60] = 1'b1; m[59] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic bit lfsr_width_ok(input int unsigned width);
        return lfsr_taps(width) != 64'd0;
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Period monitor: step counter, seed compare and saturation tracking.
// Built only when LFSR_PERIOD_MON_EN is defined.
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] next_i,
    output logic [CNT_W-1:0] period_o,
    output logic             done_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] period_q;
    logic             done_q;
    logic             ovf_q;
    logic             open;

    assign cnt_d = cnt_q + CNT_W'(1);
    // Only the first return to the seed counts, and only before saturation.
    assign open  = !done_q && !ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            seed_q   <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (clr_i) begin
            cnt_q    <= '0;
            seed_q   <= seed_i;
            period_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (step_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_d;
            end
            if (open) begin
                if (next_i == seed_q) begin
                    period_q <= cnt_d;
                    done_q   <= 1'b1;
                end else if (cnt_d == CNT_MAX) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign period_o = period_q;
    assign done_o   = done_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/lfsr_period_gen.sv
// Fibonacci LFSR with run-time seed load, zero-seed lock and an optional
// period monitor enabled by LFSR_PERIOD_MON_EN.
module lfsr_period_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] state,
    output logic             valid,
    output logic             zero_lock,
    output logic [CNT_W-1:0] period,
    output logic             period_done,
    output logic             period_ovf
);

    if (!lfsr_width_ok(WIDTH)) begin : g_bad_width
        $error("lfsr_period_gen: unsupported WIDTH %0d", WIDTH);
    end

    localparam logic [63:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    lfsr_fsm_e        fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             valid_q;
    logic             zl_q;
    logic             fb;

    assign fb      = ^(state_q & TAPS);
    assign state_d = {state_q[WIDTH-2:0], fb};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            valid_q <= 1'b0;
            zl_q    <= 1'b0;
        end else if (load) begin
            state_q <= seed;
            if (seed == '0) begin
                fsm_q   <= STUCK;
                valid_q <= 1'b0;
                zl_q    <= 1'b1;
            end else begin
                fsm_q   <= RUN;
                valid_q <= 1'b1;
                zl_q    <= 1'b0;
            end
        end else if (fsm_q == RUN && en) begin
            state_q <= state_d;
        end
    end

    assign state     = state_q;
    assign valid     = valid_q;
    assign zero_lock = zl_q;

`ifdef LFSR_PERIOD_MON_EN
    logic step;

    assign step = (fsm_q == RUN) && en && !load;

    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mon (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (load),
        .seed_i   (seed),
        .step_i   (step),
        .next_i   (state_d),
        .period_o (period),
        .done_o   (period_done),
        .ovf_o    (period_ovf)
    );
`else
    assign period      = '0;
    assign period_done = 1'b0;
    assign period_ovf  = 1'b0;
`endif

endmodule
